// File: rtl/oam_dma_master.sv
// NES sprite DMA initiator: a CPU write to $4014 stalls the CPU and copies
// one 256-byte page to the PPU OAM data port through the shared memory bus.
module oam_dma_master #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        dma_halt,
    output logic        bus_cs_n,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    input  logic [7:0]  bus_din,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic       parity;
    logic [7:0] idx;
    logic [7:0] page;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            parity   <= 1'b0;
            idx      <= 8'd0;
            page     <= 8'd0;
            dma_halt <= 1'b0;
            bus_cs_n <= 1'b1;
            bus_rd   <= 1'b0;
            bus_wr   <= 1'b0;
            bus_addr <= 16'd0;
            bus_dout <= 8'd0;
            bus_oe   <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            if (cpu_ce) begin
                parity <= ~parity;
                unique case (state)
                    IDLE: begin
                        if (cpu_wr && cpu_addr == DMA_REG_ADDR) begin
                            page     <= cpu_dout;
                            idx      <= 8'd0;
                            dma_halt <= 1'b1;
                            state    <= HALT;
                        end
                    end
                    HALT: begin
                        // Reads must land on an even CPU cycle
                        if (parity) begin
                            state <= ALIGN;
                        end else begin
                            state    <= READ;
                            bus_cs_n <= 1'b0;
                            bus_rd   <= 1'b1;
                            bus_addr <= {page, idx};
                        end
                    end
                    ALIGN: begin
                        state    <= READ;
                        bus_cs_n <= 1'b0;
                        bus_rd   <= 1'b1;
                        bus_addr <= {page, idx};
                    end
                    READ: begin
                        state    <= WRITE;
                        bus_rd   <= 1'b0;
                        bus_wr   <= 1'b1;
                        bus_oe   <= 1'b1;
                        bus_addr <= OAM_DATA_ADDR;
                        bus_dout <= bus_din;
                    end
                    WRITE: begin
                        bus_wr <= 1'b0;
                        bus_oe <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state    <= IDLE;
                            idx      <= 8'd0;
                            dma_halt <= 1'b0;
                            dma_done <= 1'b1;
                            bus_cs_n <= 1'b1;
                            bus_addr <= 16'd0;
                        end else begin
                            state    <= READ;
                            idx      <= idx + 8'd1;
                            bus_rd   <= 1'b1;
                            bus_addr <= {page, idx + 8'd1};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_master.sv
// Directed bench for oam_dma_master with a synchronous 1-clk-latency memory
// and a CPU-cycle driver that records every DMA bus write.
module tb_oam_dma_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        dma_halt;
    logic        bus_cs_n;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_oe;
    logic [7:0]  bus_din;
    logic        dma_done;

    oam_dma_master dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_ce   (cpu_ce),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .dma_halt (dma_halt),
        .bus_cs_n (bus_cs_n),
        .bus_rd   (bus_rd),
        .bus_wr   (bus_wr),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din),
        .dma_done (dma_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    always @(posedge clk) bus_din <= mem[bus_addr];

    int          checks = 0;
    int          errors = 0;
    int          ce_cnt;
    int          halt_cnt;
    int          done_cnt;
    bit          rd_seen;
    logic [15:0] rd_addr;
    logic [23:0] wq [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One CPU cycle: ce high for one clk, then gap idle clks
    task automatic cpu_cycle(input logic wr, input logic [15:0] addr,
                             input logic [7:0] d, input int gap);
        @(negedge clk);
        cpu_ce   = 1'b1;
        cpu_wr   = wr;
        cpu_addr = addr;
        cpu_dout = d;
        @(posedge clk);
        if (dma_halt) halt_cnt++;
        if (bus_wr) wq.push_back({bus_addr, bus_dout});
        if (bus_rd && !rd_seen) begin
            rd_seen = 1'b1;
            rd_addr = bus_addr;
        end
        ce_cnt++;
        @(negedge clk);
        if (dma_done) done_cnt++;
        cpu_ce = 1'b0;
        cpu_wr = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic clear_log();
        wq.delete();
        halt_cnt = 0;
        done_cnt = 0;
        rd_seen  = 1'b0;
        rd_addr  = 16'hxxxx;
    endtask

    // Issue the $4014 write so DUT parity right after it equals par
    task automatic trigger(input logic [7:0] pg, input bit par,
                           input int gap);
        if (((ce_cnt + 1) & 1) != int'(par)) cpu_cycle(1'b0, 16'h0000, 8'h00, gap);
        clear_log();
        cpu_cycle(1'b1, 16'h4014, pg, gap);
    endtask

    task automatic run_xfer(input int gap);
        for (int i = 0; i < 600 && done_cnt == 0; i++)
            cpu_cycle(1'b0, 16'h0000, 8'h00, gap);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] pg,
                              input int exp_halt);
        int bad;
        logic [23:0] e;
        chk({tag, "_halt_cycles"}, halt_cnt, exp_halt);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_first_rd"}, {16'h0, rd_addr}, {16'h0, pg, 8'h00});
        chk({tag, "_n_writes"}, wq.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < wq.size(); i++) begin
            e = {16'h2004, mem[{pg, 8'(i)}]};
            if (wq[i] !== e) begin
                if (bad == 0)
                    $display("FAIL %s_byte%0d got %h exp %h", tag, i, wq[i], e);
                bad++;
            end
        end
        chk({tag, "_bad_bytes"}, bad, 0);
        chk({tag, "_last_data"}, {8'h0, wq.size() > 0 ? wq[wq.size() - 1] : 24'hx},
            {8'h0, 16'h2004, mem[{pg, 8'hFF}]});
        cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        chk({tag, "_halt_after"}, dma_halt, 1'b0);
        chk({tag, "_cs_after"}, bus_cs_n, 1'b1);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++)
            mem[a] = 8'((a * 7) ^ ((a >> 8) * 13) ^ 8'h5A);
        rst = 1'b1;
        cpu_ce = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = 16'h0;
        cpu_dout = 8'h0;
        ce_cnt = 0;
        clear_log();

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_halt", dma_halt, 1'b0);
        chk("rst_cs_n", bus_cs_n, 1'b1);
        chk("rst_rd", bus_rd, 1'b0);
        chk("rst_wr", bus_wr, 1'b0);
        chk("rst_addr", bus_addr, 16'h0);
        chk("rst_dout", bus_dout, 8'h0);
        chk("rst_oe", bus_oe, 1'b0);
        chk("rst_done", dma_done, 1'b0);

        // Even trigger
        trigger(8'h02, 1'b0, 3);
        chk("even_halt_on", dma_halt, 1'b1);
        chk("even_cs_halt", bus_cs_n, 1'b1);
        run_xfer(3);
        check_xfer("even", 8'h02, 513);

        // Odd trigger visits ALIGN
        trigger(8'h02, 1'b1, 3);
        run_xfer(3);
        check_xfer("odd", 8'h02, 514);

        // ROM page, ce every 2 clk
        trigger(8'h80, 1'b0, 2);
        run_xfer(2);
        check_xfer("rom", 8'h80, 513);

        // Non-triggers
        clear_log();
        cpu_cycle(1'b1, 16'h4015, 8'h02, 2);
        cpu_cycle(1'b1, 16'h2004, 8'h02, 2);
        cpu_cycle(1'b0, 16'h4014, 8'h02, 2);
        cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        chk("nontrig_halt", dma_halt, 1'b0);
        chk("nontrig_cs", bus_cs_n, 1'b1);
        chk("nontrig_halt_cnt", halt_cnt, 0);

        // Trigger with reset: reset wins
        rst = 1'b1;
        cpu_cycle(1'b1, 16'h4014, 8'h05, 2);
        rst = 1'b0;
        ce_cnt = 0;
        cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        chk("rsttrig_halt", dma_halt, 1'b0);
        chk("rsttrig_cs", bus_cs_n, 1'b1);

        // Abort at idx 100 WRITE
        trigger(8'h03, 1'b0, 2);
        for (int i = 0; i < 400 && !(wq.size() == 100 && bus_wr); i++)
            cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        chk("abort_reached", {wq.size() == 100, bus_wr}, 2'b11);
        chk("abort_wr_addr", bus_addr, 16'h2004);
        chk("abort_wr_data", bus_dout, mem[16'h0364]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce_cnt = 0;
        chk("abort_halt", dma_halt, 1'b0);
        chk("abort_cs", bus_cs_n, 1'b1);
        chk("abort_wr", bus_wr, 1'b0);
        chk("abort_oe", bus_oe, 1'b0);
        cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        cpu_cycle(1'b0, 16'h0000, 8'h00, 2);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", dma_halt, 1'b0);

        // Restart from idx 0
        trigger(8'h03, 1'b1, 2);
        run_xfer(2);
        check_xfer("restart", 8'h03, 514);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
